instr_encoder_rv32i: RTL and testbench

- Inverse of the RV32I funct7 decoder. Accepts instruction-field requests, including a one-hot funct7 class select {0x0, 0x1, 0x2, 0x3, 0x20}.
- Packs each request into a 32-bit R-type or I-type RV32I word and buffers it in a small FIFO.
- Streams buffered words into instruction memory through a write port with an auto-incrementing word address.
- Used by test/boot infrastructure to build programs for the core without a host assembler.

---
 rtl/rv32i_enc_pkg.sv | 58 +++++
 rtl/instr_encoder_rv32i_sync_fifo.sv | 55 +++++
 rtl/instr_encoder_rv32i.sv | 100 ++++++++++
 tb/tb_instr_encoder_rv32i.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_enc_pkg.sv
// Shared constants, request/result types and the field packer for the
// RV32I instruction encoder.
package rv32i_enc_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_MULDIV = 7'h01;
  localparam logic [6:0] F7_X2     = 7'h02;
  localparam logic [6:0] F7_X3     = 7'h03;
  localparam logic [6:0] F7_ALT    = 7'h20;

  typedef struct packed {
    logic        fmt;
    logic [4:0]  f7sel;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
  } enc_req_t;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_res_t;

  function automatic enc_res_t encode_rv32i(input enc_req_t r);
    enc_res_t   res;
    logic [6:0] f7;
    logic       oneHot;
    res    = '0;
    f7     = F7_BASE;
    oneHot = 1'b1;
    case (r.f7sel)
      5'b00001: f7 = F7_BASE;
      5'b00010: f7 = F7_MULDIV;
      5'b00100: f7 = F7_X2;
      5'b01000: f7 = F7_X3;
      5'b10000: f7 = F7_ALT;
      default:  oneHot = 1'b0;
    endcase
    if (!r.fmt) begin
      res.legal = oneHot;
      res.word  = {f7, r.rs2, r.rs1, r.f3, r.rd, OPC_OP};
    end else if (r.f3 == 3'd1 || r.f3 == 3'd5) begin
      // Shift-immediates reuse the funct7 slot; only SRAI may carry the alt bit.
      res.legal = oneHot && (f7 == F7_BASE || (r.f3 == 3'd5 && f7 == F7_ALT));
      res.word  = {f7, r.imm[4:0], r.rs1, r.f3, r.rd, OPC_OP_IMM};
    end else begin
      res.legal = 1'b1;
      res.word  = {r.imm, r.rs1, r.f3, r.rd, OPC_OP_IMM};
    end
    return res;
  endfunction

endpackage

// File: rtl/instr_encoder_rv32i_sync_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; head reads as zero when empty.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wptr_q, wptr_d;
  logic [PW:0]      rptr_q, rptr_d;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign count = wptr_q - rptr_q;
  assign dout  = empty ? '0 : mem_q[rptr_q[PW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push && !full) wptr_d = wptr_q + 1'b1;
      if (pop && !empty) rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !clr) mem_q[wptr_q[PW-1:0]] <= din;
  end

endmodule

// File: rtl/instr_encoder_rv32i.sv
// Packs R/I-type RV32I requests into words, buffers them and streams them
// into instruction memory at an auto-incrementing address.
module instr_encoder_rv32i
  import rv32i_enc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 8,
  parameter int BASE  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_fmt,
  input  logic [4:0]              req_f7sel,
  input  logic [2:0]              req_f3,
  input  logic [4:0]              req_rd,
  input  logic [4:0]              req_rs1,
  input  logic [4:0]              req_rs2,
  input  logic [11:0]             req_imm,
  output logic                    mem_we,
  input  logic                    mem_ready,
  output logic [AW-1:0]           mem_addr,
  output logic [31:0]             mem_wdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    err,
  output logic [7:0]              err_cnt
);

  enc_req_t      req;
  enc_res_t      enc;
  logic          full, empty;
  logic          accept, push, pop, bad;
  logic          ready_q;
  logic [AW-1:0] addr_q, addr_d;
  logic          err_q, err_d;
  logic [7:0]    errCnt_q, errCnt_d;

  assign req = '{fmt: req_fmt, f7sel: req_f7sel, f3: req_f3, rd: req_rd,
                 rs1: req_rs1, rs2: req_rs2, imm: req_imm};
  assign enc = encode_rv32i(req);

  assign req_ready = ready_q && !full;
  assign accept    = req_valid && req_ready;
  assign push      = accept && enc.legal && !clr;
  assign bad       = accept && !enc.legal && !clr;
  assign pop       = mem_we && mem_ready && !clr;

  assign mem_we   = !empty;
  assign mem_addr = addr_q;
  assign err      = err_q;
  assign err_cnt  = errCnt_q;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (enc.word),
    .dout  (mem_wdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    addr_d   = addr_q;
    err_d    = err_q;
    errCnt_d = errCnt_q;
    if (clr) begin
      addr_d   = AW'(BASE);
      err_d    = 1'b0;
      errCnt_d = '0;
    end else begin
      // Address wraps naturally through all-ones to zero, not back to BASE.
      if (pop) addr_d = addr_q + 1'b1;
      if (bad) begin
        err_d = 1'b1;
        if (errCnt_q != 8'hFF) errCnt_d = errCnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q  <= 1'b0;
      addr_q   <= AW'(BASE);
      err_q    <= 1'b0;
      errCnt_q <= '0;
    end else begin
      ready_q  <= 1'b1;
      addr_q   <= addr_d;
      err_q    <= err_d;
      errCnt_q <= errCnt_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder_rv32i.sv
// Self-checking bench for instr_encoder_rv32i: directed plan steps plus a
// randomized phase, all compared against a queue-based reference model.
module tb_instr_encoder_rv32i;

  localparam int DEPTH = 4;
  localparam int AW    = 8;
  localparam int BASE  = 0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_fmt = 1'b0;
  logic [4:0]    req_f7sel = '0;
  logic [2:0]    req_f3 = '0;
  logic [4:0]    req_rd = '0, req_rs1 = '0, req_rs2 = '0;
  logic [11:0]   req_imm = '0;
  logic          mem_we;
  logic          mem_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [2:0]    count;
  logic          err;
  logic [7:0]    err_cnt;

  instr_encoder_rv32i #(.DEPTH(DEPTH), .AW(AW), .BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fmt(req_fmt), .req_f7sel(req_f7sel), .req_f3(req_f3),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .count(count), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [31:0] mq[$];
  int          mAddr = BASE;
  bit          mErr = 0;
  int          mErrCnt = 0;
  bit          mReady = 0;
  bit          accFlag;

  // Reference encoder written straight from the field layout with arithmetic.
  function automatic bit refEncode(input logic fmt, input logic [4:0] sel,
                                   input int f3, input int rd, input int rs1,
                                   input int rs2, input int imm,
                                   output logic [31:0] word);
    longint unsigned w;
    int  f7;
    bit  one;
    one = ($countones(sel) == 1);
    f7  = 0;
    if (one) f7 = (sel == 5'd16) ? 32 : (sel == 5'd8) ? 3 : (sel == 5'd4) ? 2 :
                  (sel == 5'd2) ? 1 : 0;
    if (!fmt) begin
      w = longint'(f7) * 2**25 + rs2 * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + 'h33;
      word = w[31:0];
      return one;
    end
    if (f3 == 1 || f3 == 5) begin
      w = longint'(f7) * 2**25 + (imm % 32) * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + 'h13;
      word = w[31:0];
      return one && (f7 == 0 || (f3 == 5 && f7 == 32));
    end
    w = longint'(imm) * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + 'h13;
    word = w[31:0];
    return 1'b1;
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    check32({tag, ":req_ready"}, 32'(req_ready), 32'(mReady && mq.size() < DEPTH));
    check32({tag, ":mem_we"},    32'(mem_we),    32'(mq.size() != 0));
    check32({tag, ":mem_wdata"}, mem_wdata,      (mq.size() != 0) ? mq[0] : 32'h0);
    check32({tag, ":mem_addr"},  32'(mem_addr),  32'(mAddr));
    check32({tag, ":count"},     32'(count),     32'(mq.size()));
    check32({tag, ":err"},       32'(err),       32'(mErr));
    check32({tag, ":err_cnt"},   32'(err_cnt),   32'(mErrCnt));
  endtask

  task automatic modelReset();
    mq.delete();
    mAddr = BASE; mErr = 0; mErrCnt = 0; mReady = 0;
  endtask

  // One clock cycle: predict from pre-edge state, advance, compare.
  task automatic tick(input string tag, output bit acc);
    bit          legal, pop;
    logic [31:0] w;
    legal = refEncode(req_fmt, req_f7sel, int'(req_f3), int'(req_rd), int'(req_rs1),
                      int'(req_rs2), int'(req_imm), w);
    acc = req_valid && mReady && (mq.size() < DEPTH);
    pop = (mq.size() != 0) && mem_ready;
    @(posedge clk); #1;
    if (clr) begin
      mq.delete(); mAddr = BASE; mErr = 0; mErrCnt = 0;
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        mAddr = (mAddr + 1) % (2**AW);
      end
      if (acc && legal) mq.push_back(w);
      if (acc && !legal) begin
        mErr = 1;
        if (mErrCnt < 255) mErrCnt++;
      end
    end
    mReady = 1;
    checkOutput(tag);
  endtask

  task automatic applyStimulus(input string tag, input logic v, input logic fmt,
                               input logic [4:0] sel, input logic [2:0] f3,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [11:0] imm);
    req_valid = v; req_fmt = fmt; req_f7sel = sel; req_f3 = f3;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    tick(tag, accFlag);
  endtask

  task automatic idle(input string tag);
    req_valid = 1'b0;
    tick(tag, accFlag);
  endtask

  task automatic randReq(input bit forceLegal);
    logic [4:0] oneHot;
    oneHot    = 5'd1 << $urandom_range(4, 0);
    req_fmt   = 1'($urandom);
    req_f3    = 3'($urandom);
    req_rd    = 5'($urandom);
    req_rs1   = 5'($urandom);
    req_rs2   = 5'($urandom);
    req_imm   = 12'($urandom);
    req_f7sel = ($urandom_range(3, 0) == 0) ? 5'($urandom) : oneHot;
    if (forceLegal) begin
      req_fmt   = 1'b0;
      req_f7sel = oneHot;
    end
  endtask

  initial begin
    // Reset state while rst_n is held low
    #12;
    modelReset();
    checkOutput("reset");
    rst_n = 1'b1;
    idle("release");
    mem_ready = 1'b1;

    // add x3, x1, x2
    applyStimulus("add", 1, 0, 5'b00001, 3'd0, 5'd3, 5'd1, 5'd2, 12'd0);
    check32("add_word", mem_wdata, 32'h002081B3);
    check32("add_addr", 32'(mem_addr), 32'd0);
    idle("add_done");
    check32("add_addr_next", 32'(mem_addr), 32'd1);

    // sub x5, x6, x7 followed by addi x1, x0, -1
    applyStimulus("sub", 1, 0, 5'b10000, 3'd0, 5'd5, 5'd6, 5'd7, 12'd0);
    check32("sub_word", mem_wdata, 32'h407302B3);
    applyStimulus("addi", 1, 1, 5'b00000, 3'd0, 5'd1, 5'd0, 5'd0, 12'hFFF);
    check32("addi_word", mem_wdata, 32'hFFF00093);
    check32("addi_addr", 32'(mem_addr), 32'd2);
    idle("addi_done");

    // srai x2, x2, 3 then illegal slli with alt select
    applyStimulus("srai", 1, 1, 5'b10000, 3'd5, 5'd2, 5'd2, 5'd0, 12'd3);
    check32("srai_word", mem_wdata, 32'h40315113);
    idle("srai_done");
    applyStimulus("slli_bad", 1, 1, 5'b10000, 3'd1, 5'd2, 5'd2, 5'd0, 12'd3);
    check32("slli_err", 32'(err), 32'd1);
    check32("slli_errcnt", 32'(err_cnt), 32'd1);
    check32("slli_we", 32'(mem_we), 32'd0);
    applyStimulus("r_bad", 1, 0, 5'b00011, 3'd0, 5'd1, 5'd1, 5'd1, 12'd0);
    check32("rbad_errcnt", 32'(err_cnt), 32'd2);
    idle("bad_done");

    // Backpressure: five legal requests against a stalled memory
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      randReq(1'b1);
      req_valid = 1'b1;
      tick("bp_fill", accFlag);
    end
    check32("bp_count", 32'(count), 32'd4);
    check32("bp_ready", 32'(req_ready), 32'd0);
    randReq(1'b1);
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick("bp_stall", accFlag);
      check32("bp_addr_hold", 32'(mem_addr), 32'd4);
    end
    mem_ready = 1'b1;
    begin
      int budget;
      budget = 0;
      do begin
        tick("bp_release", accFlag);
        budget++;
      end while (!accFlag && budget < 10);
      check32("bp_fifth_accepted", 32'(accFlag), 32'd1);
    end
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) idle("bp_drain");
    check32("bp_final_addr", 32'(mem_addr), 32'd9);

    // Randomized traffic with occasional clr
    for (int i = 0; i < 300; i++) begin
      randReq(1'b0);
      req_valid = 1'($urandom);
      mem_ready = ($urandom_range(3, 0) != 0);
      clr       = ($urandom_range(29, 0) == 0);
      tick("random", accFlag);
    end
    clr = 1'b0; req_valid = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) idle("random_drain");

    // err_cnt saturation
    clr = 1'b1;
    idle("sat_clr");
    clr = 1'b0;
    for (int i = 0; i < 260; i++)
      applyStimulus("sat", 1, 0, 5'b00000, 3'd0, 5'd1, 5'd1, 5'd1, 12'd0);
    check32("errcnt_sat", 32'(err_cnt), 32'd255);

    // Address wrap after 255 writes from BASE
    clr = 1'b1;
    idle("wrap_clr");
    clr = 1'b0;
    for (int i = 0; i < 255; i++) begin
      randReq(1'b1);
      req_valid = 1'b1;
      tick("wrap_fill", accFlag);
    end
    idle("wrap_drain");
    check32("wrap_pre_addr", 32'(mem_addr), 32'd255);
    applyStimulus("wrap_req", 1, 1, 5'b0, 3'd0, 5'd4, 5'd4, 5'd0, 12'd7);
    check32("wrap_we", 32'(mem_we), 32'd1);
    check32("wrap_addr", 32'(mem_addr), 32'd255);
    idle("wrap_done");
    check32("wrap_to_zero", 32'(mem_addr), 32'd0);

    // clr with pending writes and a simultaneous request
    applyStimulus("clr_pre", 1, 1, 5'b0, 3'd0, 5'd1, 5'd1, 5'd0, 12'd1);
    idle("clr_pre_done");
    mem_ready = 1'b0;
    applyStimulus("clr_fill1", 1, 1, 5'b0, 3'd0, 5'd2, 5'd2, 5'd0, 12'd2);
    applyStimulus("clr_fill2", 1, 1, 5'b0, 3'd0, 5'd3, 5'd3, 5'd0, 12'd3);
    applyStimulus("clr_bad", 1, 0, 5'b0, 3'd0, 5'd3, 5'd3, 5'd0, 12'd3);
    clr = 1'b1;
    applyStimulus("clr", 1, 1, 5'b0, 3'd0, 5'd4, 5'd4, 5'd0, 12'd4);
    clr = 1'b0;
    check32("clr_addr", 32'(mem_addr), 32'(BASE));
    check32("clr_count", 32'(count), 32'd0);
    check32("clr_err", 32'(err), 32'd0);
    check32("clr_we", 32'(mem_we), 32'd0);

    // Asynchronous reset pulse between edges, mid-stream
    applyStimulus("rst_fill1", 1, 1, 5'b0, 3'd0, 5'd5, 5'd5, 5'd0, 12'd5);
    applyStimulus("rst_fill2", 1, 1, 5'b0, 3'd0, 5'd6, 5'd6, 5'd0, 12'd6);
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_rst");
    #2 rst_n = 1'b1;
    mem_ready = 1'b1;
    idle("post_rst");
    check32("post_rst_ready", 32'(req_ready), 32'd1);
    applyStimulus("post_rst_req", 1, 0, 5'b00001, 3'd0, 5'd3, 5'd1, 5'd2, 12'd0);
    check32("post_rst_word", mem_wdata, 32'h002081B3);
    idle("post_rst_done");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
